soundpath_ctrl: RTL
===================

Name: soundpath_ctrl

Overview:
Controller that sequences the soundpath datapath from key press/release commands.
- Generates the periodic sample_now strobe.
- Applies note/octave/mode changes only at safe points between samples.
- Captures each completed sample for the PWM stage, and mutes the output when no key is held.
- Sits between the keypad decoder and soundpath/pwm.

Parameters:
SAMPLE_PERIOD, 256, clocks between sample_now strobes (>= 4)
DONE_TIMEOUT, 200, max clocks in WAIT_DONE before abandoning the sample (must be < SAMPLE_PERIOD)
SAMPLE_W, 9, soundpath sample width
MUTE_VALUE, 0, pwm_sample value while idle

Ports:
tb_clk  in  1  clock
tb_Rst_i  in  1  reset, asynchronous, active-low
key_valid  in  1  command strobe; accepted when key_valid & key_ready
key_on  in  1  1 = press, 0 = release
key_note  in  4  note index, valid 1..12
key_octave  in  3  octave
mode_sel  in  2  waveform mode request
key_ready  out  1  command slot free
sample_now  out  1  one-cycle strobe to soundpath
sp_mode  out  2  mode to soundpath
sp_note  out  4  note to soundpath
sp_octave  out  3  octave to soundpath
sp_sample  in  SAMPLE_W  soundpath output
sp_done  in  1  soundpath sample valid
pwm_sample  out  SAMPLE_W  held sample for PWM
pwm_load  out  1  one-cycle pulse when pwm_sample changes
active  out  1  1 when a note is sounding
timeout_err  out  1  sticky; cleared by next accepted command

Behaviour:
Reset (tb_Rst_i low): asynchronous and immediate, including mid-operation.
- state = IDLE, tick_cnt = 0, pending slot emptied.
- Output reset values: sp_mode/sp_note/sp_octave = 0, pwm_sample = MUTE_VALUE, pwm_load = 0, sample_now = 0, key_ready = 1, active = 0, timeout_err = 0.

Tick counter:
- Free-runs 0..SAMPLE_PERIOD-1 and wraps, in every state.
- tick = (tick_cnt == SAMPLE_PERIOD-1).

Command slot (one deep):
- On acceptance, the command is latched and key_ready = 0.
- Commands with key_note outside 1..12 are accepted and discarded; key_ready stays 1.

Safe cycle: state != WAIT_DONE and tick == 0.
- A pending command is applied only on a safe cycle. This guarantees sp_* are stable from sample_now until sp_done or timeout.
- Slot frees the cycle after apply.
- sp_mode is reloaded from mode_sel on every safe cycle.

Apply rules:
- Press: sp_note/sp_octave <= key values; state -> WAIT_TICK (from IDLE or WAIT_TICK).
- Release with key_note == sp_note while not IDLE: state -> IDLE. On entry, pwm_sample <= MUTE_VALUE and pwm_load pulses.
- Release of any other note: discarded.

State machine IDLE / WAIT_TICK / WAIT_DONE:
- IDLE: active = 0; no sample_now.
- WAIT_TICK: active = 1. On tick: sample_now = 1 (registered output, asserted during the cycle tick_cnt == SAMPLE_PERIOD-1); next state WAIT_DONE; wait counter cleared.
- WAIT_DONE, on sp_done: pwm_sample <= sp_sample and pwm_load = 1 in the same registered cycle; -> WAIT_TICK.
- WAIT_DONE, wait counter reaches DONE_TIMEOUT without sp_done: timeout_err <= 1; pwm_sample held; -> WAIT_TICK.
- sp_done coinciding with timeout expiry: done wins, and timeout_err is not set.
- sp_done outside WAIT_DONE: ignored.
- No strobe is ever issued while in WAIT_DONE.

Latency:
- Press accepted in IDLE at cycle t with tick_cnt != SAMPLE_PERIOD-1: sp_note updated at t+1.
- First sample_now occurs at the next tick.

Simultaneous events:
- Command acceptance in the same cycle as apply of the previous command: not possible, because key_ready is low until the slot frees.
- Accepted command in the same cycle as tick: the command is applied at the next safe cycle, i.e. after that sample's done/timeout.

Decomposition:
soundpath_pkg holds:
- ctrl_state_t enum {IDLE, WAIT_TICK, WAIT_DONE}
- NOTE_W = 4, OCT_W = 3, MODE_W = 2
- NOTE_MIN = 1, NOTE_MAX = 12

Sub-module sample_tick_gen (parameter SAMPLE_PERIOD; outputs tick_cnt and tick). The FSM, command slot and capture logic stay in soundpath_ctrl.

Test Plan:
- Reset then idle 1000 clocks -> sample_now never asserted; pwm_sample = 0; key_ready = 1; active = 0.
- Press note 12, octave 6, mode_sel 3 -> sp_note = 12, sp_octave = 6, sp_mode = 3 next cycle. sample_now asserts exactly once per 256 clocks. sp_done with sp_sample = 9'h1A5 -> pwm_sample = 9'h1A5 with a one-cycle pwm_load.
- Press note 5 asserted on the tick cycle, while running note 12 -> key_ready stays 0 through WAIT_DONE. sp_note changes to 5 only after sp_done, and never between sample_now and sp_done.
- Release note 3 while note 5 is sounding -> ignored, active stays 1. Release note 5 -> state IDLE, pwm_sample = 0 with pwm_load pulse, no further strobes.
- Withhold sp_done after a strobe -> timeout_err = 1 exactly 200 clocks later; pwm_sample unchanged; next strobe still on schedule. A subsequent accepted press clears timeout_err.
- Assert tb_Rst_i low in WAIT_DONE with a pending command -> all outputs at reset values immediately; pending command lost. A late sp_done after reset is ignored.

Source files
------------

// File: rtl/soundpath_pkg.sv
// Shared types and field widths for the soundpath control slice.
package soundpath_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        WAIT_DONE = 2'd2
    } ctrl_state_t;

    localparam int NOTE_W = 4;
    localparam int OCT_W  = 3;
    localparam int MODE_W = 2;

    localparam logic [NOTE_W-1:0] NOTE_MIN = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_MAX = 4'd12;

    function automatic logic note_ok(input logic [NOTE_W-1:0] note);
        return (note >= NOTE_MIN) && (note <= NOTE_MAX);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-period counter; tick marks the last count of each period.
module sample_tick_gen #(
    parameter int SAMPLE_PERIOD = 256
) (
    input  logic                             tb_clk,
    input  logic                             tb_Rst_i,
    output logic [$clog2(SAMPLE_PERIOD)-1:0] tick_cnt,
    output logic                             tick
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_PERIOD - 1);

    assign tick = (tick_cnt == LAST);

    always_ff @(posedge tb_clk or negedge tb_Rst_i) begin
        if (!tb_Rst_i)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

endmodule

// File: rtl/soundpath_ctrl.sv
// Sequences the soundpath: strobes samples, applies key commands between samples,
// and hands completed samples (or mute) to the PWM stage.
module soundpath_ctrl
    import soundpath_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 256,
    parameter int DONE_TIMEOUT  = 200,
    parameter int SAMPLE_W      = 9,
    parameter int MUTE_VALUE    = 0
) (
    input  logic                tb_clk,
    input  logic                tb_Rst_i,
    input  logic                key_valid,
    input  logic                key_on,
    input  logic [NOTE_W-1:0]   key_note,
    input  logic [OCT_W-1:0]    key_octave,
    input  logic [MODE_W-1:0]   mode_sel,
    output logic                key_ready,
    output logic                sample_now,
    output logic [MODE_W-1:0]   sp_mode,
    output logic [NOTE_W-1:0]   sp_note,
    output logic [OCT_W-1:0]    sp_octave,
    input  logic [SAMPLE_W-1:0] sp_sample,
    input  logic                sp_done,
    output logic [SAMPLE_W-1:0] pwm_sample,
    output logic                pwm_load,
    output logic                active,
    output logic                timeout_err
);

    localparam int CNT_W  = $clog2(SAMPLE_PERIOD);
    localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    PRE_LAST  = CNT_W'(SAMPLE_PERIOD - 2);
    localparam logic [WAIT_W-1:0]   DONE_LAST = WAIT_W'(DONE_TIMEOUT - 1);
    localparam logic [SAMPLE_W-1:0] MUTE      = SAMPLE_W'(MUTE_VALUE);

    ctrl_state_t       state, state_nxt;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [WAIT_W-1:0] wait_cnt;

    logic              slot_vld, slot_applied, slot_on;
    logic [NOTE_W-1:0] slot_note;
    logic [OCT_W-1:0]  slot_oct;

    logic              accept, accept_ok, cmd_pend, safe, apply;
    logic              cmd_on, apply_press, apply_rel, done_hit, expire;
    logic [NOTE_W-1:0] cmd_note;
    logic [OCT_W-1:0]  cmd_oct;

    sample_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
        .tb_clk   (tb_clk),
        .tb_Rst_i (tb_Rst_i),
        .tick_cnt (tick_cnt),
        .tick     (tick)
    );

    assign key_ready = !slot_vld;
    assign active    = (state != IDLE);

    // A command arriving into an empty slot is applied straight from the inputs when safe.
    assign accept      = key_valid && key_ready;
    assign accept_ok   = accept && note_ok(key_note);
    assign cmd_pend    = (slot_vld && !slot_applied) || accept_ok;
    assign cmd_on      = slot_vld ? slot_on   : key_on;
    assign cmd_note    = slot_vld ? slot_note : key_note;
    assign cmd_oct     = slot_vld ? slot_oct  : key_octave;
    assign safe        = (state != WAIT_DONE) && !tick;
    assign apply       = cmd_pend && safe;
    assign apply_press = apply && cmd_on;
    assign apply_rel   = apply && !cmd_on && (cmd_note == sp_note) && (state != IDLE);
    assign done_hit    = (state == WAIT_DONE) && sp_done;
    assign expire      = (state == WAIT_DONE) && !sp_done && (wait_cnt == DONE_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (apply_press) state_nxt = WAIT_TICK;
            WAIT_TICK: begin
                if (tick)           state_nxt = WAIT_DONE;
                else if (apply_rel) state_nxt = IDLE;
            end
            WAIT_DONE: if (done_hit || expire) state_nxt = WAIT_TICK;
            default:   state_nxt = IDLE;
        endcase
    end

    // sample_now is registered one cycle early so it lands on the tick cycle itself.
    always_ff @(posedge tb_clk or negedge tb_Rst_i) begin
        if (!tb_Rst_i) begin
            state        <= IDLE;
            sample_now   <= 1'b0;
            sp_mode      <= '0;
            sp_note      <= '0;
            sp_octave    <= '0;
            pwm_sample   <= MUTE;
            pwm_load     <= 1'b0;
            timeout_err  <= 1'b0;
            slot_vld     <= 1'b0;
            slot_applied <= 1'b0;
        end else begin
            state      <= state_nxt;
            sample_now <= (tick_cnt == PRE_LAST) && (state_nxt == WAIT_TICK);
            pwm_load   <= 1'b0;
            if (safe)
                sp_mode <= mode_sel;
            if (apply_press) begin
                sp_note   <= cmd_note;
                sp_octave <= cmd_oct;
            end
            if (done_hit) begin
                pwm_sample <= sp_sample;
                pwm_load   <= 1'b1;
            end else if (apply_rel) begin
                pwm_sample <= MUTE;
                pwm_load   <= 1'b1;
            end
            if (expire)
                timeout_err <= 1'b1;
            else if (accept)
                timeout_err <= 1'b0;
            if (slot_applied) begin
                slot_vld     <= 1'b0;
                slot_applied <= 1'b0;
            end else if (apply) begin
                slot_vld     <= 1'b1;
                slot_applied <= 1'b1;
            end else if (accept_ok) begin
                slot_vld     <= 1'b1;
                slot_applied <= 1'b0;
            end
        end
    end

    always_ff @(posedge tb_clk) begin
        if (accept_ok) begin
            slot_on   <= key_on;
            slot_note <= key_note;
            slot_oct  <= key_octave;
        end
        if ((state == WAIT_TICK) && tick)
            wait_cnt <= '0;
        else if (state == WAIT_DONE)
            wait_cnt <= wait_cnt + 1'b1;
    end

endmodule
